// File: rtl/cache_fill_ctrl_pkg.sv
// Shared cache constants, controller state encoding and address field helpers.
// Helpers work on a zero-extended 64-bit address so any configured width can use them.
package cache_fill_ctrl_pkg;

  localparam int DEF_NUM_WAYS     = 4;
  localparam int DEF_CACHE_DEPTH  = 128;
  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_LINE_WIDTH   = 128;
  localparam int MAX_ADDR_W       = 64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_MREQ   = 3'd2;
  localparam logic [2:0] ST_MWAIT  = 3'd3;
  localparam logic [2:0] ST_FILL   = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOOKUP = ST_LOOKUP,
    S_MREQ   = ST_MREQ,
    S_MWAIT  = ST_MWAIT,
    S_FILL   = ST_FILL,
    S_RESP   = ST_RESP
  } state_e;

  typedef logic [MAX_ADDR_W-1:0] addr_ext_t;

  function automatic addr_ext_t field_mask(input int width);
    return {MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - width);
  endfunction

  function automatic addr_ext_t addr_offset(input addr_ext_t addr, input int off_w);
    return addr & field_mask(off_w);
  endfunction

  function automatic addr_ext_t addr_index(input addr_ext_t addr, input int off_w, input int idx_w);
    return (addr >> off_w) & field_mask(idx_w);
  endfunction

  function automatic addr_ext_t addr_tag(input addr_ext_t addr, input int off_w, input int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

  function automatic addr_ext_t addr_line_base(input addr_ext_t addr, input int off_w);
    return addr & ~field_mask(off_w);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Request/response port and next-level memory port of the cache fill controller.
interface cache_fill_ctrl_if
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) ();

  logic                  i_req_vld;
  logic                  o_req_rdy;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  o_rsp_vld;
  logic                  i_rsp_rdy;
  logic [LINE_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_hit;
  logic                  o_mem_req_vld;
  logic                  i_mem_req_rdy;
  logic [ADDR_WIDTH-1:0] o_mem_req_addr;
  logic                  i_mem_rsp_vld;
  logic [LINE_WIDTH-1:0] i_mem_rsp_data;

  // Controller side
  modport slave (
    input  i_req_vld, i_req_addr, i_rsp_rdy, i_mem_req_rdy, i_mem_rsp_vld, i_mem_rsp_data,
    output o_req_rdy, o_rsp_vld, o_rsp_data, o_rsp_hit, o_mem_req_vld, o_mem_req_addr
  );

  // Requester plus next-level memory side
  modport master (
    output i_req_vld, i_req_addr, i_rsp_rdy, i_mem_req_rdy, i_mem_rsp_vld, i_mem_rsp_data,
    input  o_req_rdy, o_rsp_vld, o_rsp_data, o_rsp_hit, o_mem_req_vld, o_mem_req_addr
  );

endinterface

// File: rtl/cache_fill_ctrl_victim_sel.sv
// Victim way choice: lowest-numbered invalid way, otherwise the round-robin pointer.
module cache_victim_sel
  import cache_fill_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] i_valid,
  input  logic [WAY_W-1:0]    i_rr,
  output logic [WAY_W-1:0]    o_victim,
  output logic                o_all_valid
);

  logic [NUM_WAYS:0]   w_seen_free;
  logic [NUM_WAYS-1:0] w_first_free;
  logic [WAY_W-1:0]    w_free_idx;

  assign w_seen_free[0] = 1'b0;

  // w_seen_free[k] flags an invalid way somewhere below way k
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_prio
    assign w_first_free[gi]  = !i_valid[gi] && !w_seen_free[gi];
    assign w_seen_free[gi+1] = w_seen_free[gi] || !i_valid[gi];
  end

  always_comb begin
    w_free_idx = '0;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (w_first_free[k]) begin
        w_free_idx = WAY_W'(k);
      end
    end
  end

  assign o_all_valid = !w_seen_free[NUM_WAYS];
  assign o_victim    = o_all_valid ? i_rr : w_free_idx;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Set-associative cache lookup/refill controller: one request at a time, hit returns the
// stored line, miss fetches from the next level, writes a victim way, then returns the line.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int NUM_WAYS     = DEF_NUM_WAYS,
  parameter int CACHE_DEPTH  = DEF_CACHE_DEPTH,
  parameter int INDEX_WIDTH  = $clog2(CACHE_DEPTH),
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int ENTRY_WIDTH  = 1 + TAG_WIDTH + LINE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  cache_fill_ctrl_if.slave                bus,
  output logic [INDEX_WIDTH-1:0]          o_cw_ridx,
  input  logic [NUM_WAYS*ENTRY_WIDTH-1:0] i_cw_rdata,
  output logic [NUM_WAYS-1:0]             o_cw_wren,
  output logic [INDEX_WIDTH-1:0]          o_cw_widx,
  output logic [TAG_WIDTH+LINE_WIDTH-1:0] o_cw_wdata
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [LINE_WIDTH-1:0] r_rsp_data, w_rsp_data_next;
  logic                  r_hit, w_hit_next;
  logic [WAY_W-1:0]      r_victim, w_victim_next;
  logic                  r_all_valid, w_all_valid_next;
  logic [WAY_W-1:0]      r_rr, w_rr_next;

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic [ADDR_WIDTH-1:0]  w_line_addr;
  logic [NUM_WAYS-1:0]    w_valid;
  logic [NUM_WAYS-1:0]    w_hit;
  logic [TAG_WIDTH-1:0]   w_way_tag  [NUM_WAYS];
  logic [LINE_WIDTH-1:0]  w_way_line [NUM_WAYS];
  logic [LINE_WIDTH-1:0]  w_hit_line;
  logic                   w_any_hit;
  logic [WAY_W-1:0]       w_victim;
  logic                   w_all_valid;

  logic                  w_req_rdy;
  logic                  w_rsp_vld;
  logic                  w_mem_req_vld;
  logic [ADDR_WIDTH-1:0] w_mem_req_addr;

  // All way-facing fields come from the latched address, never the live request.
  assign w_index     = INDEX_WIDTH'(addr_index(MAX_ADDR_W'(r_addr), OFFSET_WIDTH, INDEX_WIDTH));
  assign w_tag       = TAG_WIDTH'(addr_tag(MAX_ADDR_W'(r_addr), OFFSET_WIDTH, INDEX_WIDTH));
  assign w_line_addr = ADDR_WIDTH'(addr_line_base(MAX_ADDR_W'(r_addr), OFFSET_WIDTH));

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    assign w_valid[gi]    = i_cw_rdata[gi*ENTRY_WIDTH + ENTRY_WIDTH - 1];
    assign w_way_tag[gi]  = i_cw_rdata[gi*ENTRY_WIDTH + LINE_WIDTH +: TAG_WIDTH];
    assign w_way_line[gi] = i_cw_rdata[gi*ENTRY_WIDTH +: LINE_WIDTH];
    assign w_hit[gi]      = w_valid[gi] && (w_way_tag[gi] == w_tag);
  end

  // Multiple hits should not happen; if they do, the lowest way wins silently.
  always_comb begin
    w_hit_line = '0;
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_hit_line = w_way_line[k];
      end
    end
  end

  assign w_any_hit = |w_hit;

  cache_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim_sel (
    .i_valid     (w_valid),
    .i_rr        (r_rr),
    .o_victim    (w_victim),
    .o_all_valid (w_all_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rsp_data  <= '0;
      r_hit       <= 1'b0;
      r_victim    <= '0;
      r_all_valid <= 1'b0;
      r_rr        <= '0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_rsp_data  <= w_rsp_data_next;
      r_hit       <= w_hit_next;
      r_victim    <= w_victim_next;
      r_all_valid <= w_all_valid_next;
      r_rr        <= w_rr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_rsp_data_next  = r_rsp_data;
    w_hit_next       = r_hit;
    w_victim_next    = r_victim;
    w_all_valid_next = r_all_valid;
    w_rr_next        = r_rr;
    w_req_rdy        = 1'b0;
    w_rsp_vld        = 1'b0;
    w_mem_req_vld    = 1'b0;
    w_mem_req_addr   = '0;
    o_cw_wren        = '0;
    o_cw_widx        = '0;
    o_cw_wdata       = '0;

    case (r_state)
      S_IDLE: begin
        w_req_rdy = 1'b1;
        if (bus.i_req_vld) begin
          w_addr_next  = bus.i_req_addr;
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_any_hit) begin
          w_rsp_data_next = w_hit_line;
          w_hit_next      = 1'b1;
          w_state_next    = S_RESP;
        end else begin
          w_victim_next    = w_victim;
          w_all_valid_next = w_all_valid;
          w_hit_next       = 1'b0;
          w_state_next     = S_MREQ;
        end
      end
      S_MREQ: begin
        w_mem_req_vld  = 1'b1;
        w_mem_req_addr = w_line_addr;
        if (bus.i_mem_req_rdy) begin
          w_state_next = S_MWAIT;
        end
      end
      S_MWAIT: begin
        if (bus.i_mem_rsp_vld) begin
          w_rsp_data_next = bus.i_mem_rsp_data;
          w_state_next    = S_FILL;
        end
      end
      S_FILL: begin
        // A reset landing on the fill cycle must not leave a half-done write behind.
        o_cw_wren  = rst_n ? (NUM_WAYS'(1'b1) << r_victim) : '0;
        o_cw_widx  = w_index;
        o_cw_wdata = {w_tag, r_rsp_data};
        if (r_all_valid) begin
          w_rr_next = r_rr + 1'b1;
        end
        w_hit_next   = 1'b0;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_vld = 1'b1;
        if (bus.i_rsp_rdy) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_cw_ridx          = w_index;
  assign bus.o_req_rdy      = w_req_rdy;
  assign bus.o_rsp_vld      = w_rsp_vld;
  assign bus.o_rsp_data     = r_rsp_data;
  assign bus.o_rsp_hit      = r_hit;
  assign bus.o_mem_req_vld  = w_mem_req_vld;
  assign bus.o_mem_req_addr = w_mem_req_addr;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: way-array stub, next-level memory driver and a per-set
// reference model of hits, victim choice and returned data.
module tb_cache_fill_ctrl;
  import cache_fill_ctrl_pkg::*;

  localparam int NW    = 4;
  localparam int DEPTH = 128;
  localparam int IW    = 7;
  localparam int OW    = 4;
  localparam int AW    = 32;
  localparam int TW    = AW - IW - OW;
  localparam int LW    = 128;
  localparam int EW    = 1 + TW + LW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  logic [IW-1:0]    cw_ridx;
  logic [NW*EW-1:0] cw_rdata;
  logic [NW-1:0]    cw_wren;
  logic [IW-1:0]    cw_widx;
  logic [TW+LW-1:0] cw_wdata;

  cache_fill_ctrl #(
    .NUM_WAYS(NW), .CACHE_DEPTH(DEPTH), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW),
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LINE_WIDTH(LW), .ENTRY_WIDTH(EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_cw_ridx  (cw_ridx),
    .i_cw_rdata (cw_rdata),
    .o_cw_wren  (cw_wren),
    .o_cw_widx  (cw_widx),
    .o_cw_wdata (cw_wdata)
  );

  // Way array stub: combinational read, write sampled mid-cycle
  bit          st_valid [NW][DEPTH];
  bit [TW-1:0] st_tag   [NW][DEPTH];
  bit [LW-1:0] st_line  [NW][DEPTH];

  int          fill_cnt = 0;
  logic [NW-1:0]    fill_wren;
  logic [IW-1:0]    fill_widx;
  logic [TW+LW-1:0] fill_wdata;

  always_comb begin
    cw_rdata = '0;
    for (int k = 0; k < NW; k++)
      cw_rdata[k*EW +: EW] = {st_valid[k][cw_ridx], st_tag[k][cw_ridx], st_line[k][cw_ridx]};
  end

  always @(negedge clk) begin
    if (cw_wren != '0) begin
      fill_cnt   <= fill_cnt + 1;
      fill_wren  <= cw_wren;
      fill_widx  <= cw_widx;
      fill_wdata <= cw_wdata;
      for (int k = 0; k < NW; k++) begin
        if (cw_wren[k]) begin
          st_valid[k][cw_widx] <= 1'b1;
          st_tag[k][cw_widx]   <= cw_wdata[TW+LW-1:LW];
          st_line[k][cw_widx]  <= cw_wdata[LW-1:0];
        end
      end
    end
  end

  // Reference model of cache contents
  bit          m_valid [NW][DEPTH];
  bit [TW-1:0] m_tag   [NW][DEPTH];
  bit [LW-1:0] m_line  [NW][DEPTH];
  int          m_rr = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_rdy"},  bus.o_req_rdy, 1);
    check_eq({tag, "_rsp_vld"},  bus.o_rsp_vld, 0);
    check_eq({tag, "_rsp_hit"},  bus.o_rsp_hit, 0);
    check_eq({tag, "_rsp_data"}, bus.o_rsp_data, 0);
    check_eq({tag, "_mreq_vld"}, bus.o_mem_req_vld, 0);
    check_eq({tag, "_mreq_adr"}, bus.o_mem_req_addr, 0);
    check_eq({tag, "_wren"},     cw_wren, 0);
    check_eq({tag, "_widx"},     cw_widx, 0);
    check_eq({tag, "_wdata"},    cw_wdata, 0);
    check_eq({tag, "_ridx"},     cw_ridx, 0);
  endtask

  // One full transaction; ms = mem request stall cycles, lat = mem response delay,
  // rs = response stall cycles, spur = drive a bogus beat while the request stalls
  task automatic do_req(input logic [AW-1:0] addr, input int ms, input int lat, input int rs,
                        input bit spur, output int way_o, output bit hit_o);
    int idx, hway, vway, exp_lat, cyc, f0, mreq_cnt, first_mreq, countdown, stall_left;
    logic [TW-1:0] tag;
    logic [AW-1:0] laddr;
    logic [LW-1:0] exp_line, new_line;
    bit exp_hit;

    idx   = int'((addr >> OW) % DEPTH);
    tag   = TW'(addr >> (OW + IW));
    laddr = addr & ~32'hF;
    hway  = -1;
    for (int k = 0; k < NW; k++)
      if (hway < 0 && m_valid[k][idx] && m_tag[k][idx] == tag) hway = k;
    exp_hit  = (hway >= 0);
    new_line = {$urandom, $urandom, $urandom, $urandom};
    if (exp_hit) begin
      vway = hway;
      exp_line = m_line[hway][idx];
      exp_lat = 2;
    end else begin
      vway = -1;
      for (int k = 0; k < NW; k++)
        if (vway < 0 && !m_valid[k][idx]) vway = k;
      if (vway < 0) begin
        vway = m_rr;
        m_rr = (m_rr + 1) % NW;
      end
      exp_line = new_line;
      exp_lat = 5 + ms + lat;
    end

    f0 = fill_cnt;
    check_eq("idle_req_rdy", bus.o_req_rdy, 1);
    bus.i_req_vld  = 1'b1;
    bus.i_req_addr = addr;
    @(posedge clk); #1;
    bus.i_req_vld  = 1'b0;
    bus.i_req_addr = $urandom;
    cyc = 1;
    check_eq("busy_req_rdy", bus.o_req_rdy, 0);
    check_eq("lookup_ridx", cw_ridx, idx);

    mreq_cnt = 0; first_mreq = -1; countdown = -1; stall_left = ms;
    while (!bus.o_rsp_vld && cyc < 300) begin
      bus.i_mem_rsp_vld  = 1'b0;
      bus.i_mem_rsp_data = '0;
      bus.i_mem_req_rdy  = 1'b0;
      if (bus.o_mem_req_vld) begin
        mreq_cnt++;
        if (first_mreq < 0) first_mreq = cyc;
        check_eq("mreq_addr", bus.o_mem_req_addr, laddr);
        if (stall_left > 0) begin
          stall_left--;
          if (spur) begin
            bus.i_mem_rsp_vld  = 1'b1;
            bus.i_mem_rsp_data = ~new_line;
          end
        end else begin
          bus.i_mem_req_rdy = 1'b1;
          countdown = lat;
        end
      end else if (countdown == 0) begin
        bus.i_mem_rsp_vld  = 1'b1;
        bus.i_mem_rsp_data = new_line;
        countdown = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_mem_rsp_vld = 1'b0;
    bus.i_mem_req_rdy = 1'b0;

    check_eq("rsp_arrived", bus.o_rsp_vld, 1);
    check_eq("latency", cyc, exp_lat);
    check_eq("rsp_hit", bus.o_rsp_hit, exp_hit);
    check_eq("rsp_data", bus.o_rsp_data, exp_line);
    check_eq("mreq_cycles", mreq_cnt, exp_hit ? 0 : ms + 1);
    check_eq("fill_count", fill_cnt - f0, exp_hit ? 0 : 1);
    if (!exp_hit) begin
      check_eq("mreq_first_cyc", first_mreq, 2);
      check_eq("fill_way", fill_wren, 1 << vway);
      check_eq("fill_idx", fill_widx, idx);
      check_eq("fill_data", fill_wdata, {tag, new_line});
      m_valid[vway][idx] = 1'b1;
      m_tag[vway][idx]   = tag;
      m_line[vway][idx]  = new_line;
    end

    for (int i = 0; i < rs; i++) begin
      @(posedge clk); #1;
      check_eq("hold_rsp_vld", bus.o_rsp_vld, 1);
      check_eq("hold_rsp_data", bus.o_rsp_data, exp_line);
      check_eq("hold_rsp_hit", bus.o_rsp_hit, exp_hit);
    end
    bus.i_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    bus.i_rsp_rdy = 1'b0;
    check_eq("rsp_dropped", bus.o_rsp_vld, 0);
    check_eq("back_idle", bus.o_req_rdy, 1);

    $display("req addr=%08h idx=%02h hit=%0d way=%0d lat=%0d", addr, idx, exp_hit, vway, cyc);
    way_o = vway;
    hit_o = exp_hit;
  endtask

  task automatic reset_in_mwait(input logic [AW-1:0] addr);
    int f0, cyc;
    f0 = fill_cnt;
    cyc = 0;
    bus.i_req_vld  = 1'b1;
    bus.i_req_addr = addr;
    @(posedge clk); #1;
    bus.i_req_vld = 1'b0;
    while (!bus.o_mem_req_vld && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("rst_mreq_seen", bus.o_mem_req_vld, 1);
    bus.i_mem_req_rdy = 1'b1;
    @(posedge clk); #1;
    bus.i_mem_req_rdy = 1'b0;
    check_eq("rst_mwait_mreq", bus.o_mem_req_vld, 0);
    check_eq("rst_mwait_rsp", bus.o_rsp_vld, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("rst_mwait");
    rst_n = 1'b1;
    m_rr = 0;
    // The dropped refill's beat shows up late; an idle controller must ignore it
    bus.i_mem_rsp_vld  = 1'b1;
    bus.i_mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.i_mem_rsp_vld = 1'b0;
    check_eq("rst_still_idle", bus.o_req_rdy, 1);
    check_eq("rst_no_write", fill_cnt - f0, 0);
    $display("req addr=%08h reset during refill wait", addr);
  endtask

  int          way;
  bit          hit;
  int          conf_way [6] = '{0, 1, 2, 3, 0, 1};
  logic [TW-1:0] rpool [6];
  int          ipool [3] = '{5, 'h23, 'h7F};
  logic [AW-1:0] a;

  initial begin
    bus.i_req_vld = 1'b0;
    bus.i_req_addr = '0;
    bus.i_rsp_rdy = 1'b0;
    bus.i_mem_req_rdy = 1'b0;
    bus.i_mem_rsp_vld = 1'b0;
    bus.i_mem_rsp_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss, then a hit on the same line
    do_req(32'h0000_1230, 0, 0, 0, 1'b0, way, hit);
    check_eq("cold_way", way, 0);
    check_eq("cold_hit", hit, 0);
    do_req(32'h0000_1230, 0, 0, 0, 1'b0, way, hit);
    check_eq("warm_hit", hit, 1);

    // Six distinct tags on index 5
    for (int i = 0; i < 6; i++) begin
      a = (32'(32'h10 + i) << (OW + IW)) | (32'd5 << OW);
      do_req(a, 0, 0, 0, 1'b0, way, hit);
      check_eq("conflict_way", way, conf_way[i]);
    end

    // Stalled memory request with a spurious beat, stalled response
    do_req(32'h0000_4560, 3, 1, 4, 1'b1, way, hit);

    // Reset while waiting on memory; the same line must miss afterwards
    reset_in_mwait(32'h0000_7890);
    do_req(32'h0000_7890, 0, 0, 0, 1'b0, way, hit);
    check_eq("post_reset_miss", hit, 0);

    rpool[0] = TW'(2);
    rpool[1] = TW'(32'h10);
    for (int i = 2; i < 6; i++) rpool[i] = TW'($urandom);
    for (int n = 0; n < 80; n++) begin
      a = (32'(rpool[$urandom_range(0, 5)]) << (OW + IW))
        | (32'(ipool[$urandom_range(0, 2)]) << OW)
        | 32'($urandom_range(0, 15));
      do_req(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), way, hit);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000");
    $fatal(1, "simulation time limit reached");
  end

endmodule
